reorder_fifo: RTL and testbench

In-order reorder buffer sitting between dispatch and commit in the backend. Dispatch pushes one instruction record per cycle in program order. Commit reads the oldest record show-ahead and pops it once the destination has written back. A commit abort (mispredict, trap or xRet) flushes every in-flight record in one cycle.

---
 rtl/reorder_fifo.sv | 74 +++++++
 tb/tb_reorder_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/reorder_fifo.sv
// reorder_fifo: in-order reorder buffer between dispatch and commit, show-ahead read, one-cycle flush.
// Defining REORDER_OCCUPANCY_EN adds the reOrder_occupancy port (wptr - rptr).
`ifndef RB
`define RB 6
`endif
`ifndef REORDER_INFO_DW
`define REORDER_INFO_DW (64 + 5 + `RB + 6)
`endif

module reorder_fifo #(
    parameter int DP = 4,
    localparam int AW = $clog2(DP)
) (
    input  logic                        CLK,
    input  logic                        RSTn,
    input  logic [`REORDER_INFO_DW-1:0] dispat_info,
    input  logic                        reOrder_fifo_push,
    output logic                        reOrder_fifo_full,
    output logic [`REORDER_INFO_DW-1:0] commit_fifo,
    output logic                        reOrder_fifo_empty,
    input  logic                        reOrder_fifo_pop,
    input  logic                        commit_abort
`ifdef REORDER_OCCUPANCY_EN
    ,
    output logic [AW:0]                 reOrder_occupancy
`endif
);

    localparam int DW = `REORDER_INFO_DW;
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [DW-1:0] mem [DP];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          push_ok;
    logic          pop_ok;

    // Handshake: push/pop are requests, full/empty are the ready-side flags; a transfer
    // happens only when request & flag-permits & ~commit_abort, otherwise it is dropped.
    assign reOrder_fifo_empty = (wptr == rptr);
    assign reOrder_fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push_ok = reOrder_fifo_push && !reOrder_fifo_full && !commit_abort;
    assign pop_ok  = reOrder_fifo_pop && !reOrder_fifo_empty && !commit_abort;

    // Show-ahead head; valid only when ~empty.
    assign commit_fifo = mem[rptr[AW-1:0]];

`ifdef REORDER_OCCUPANCY_EN
    assign reOrder_occupancy = wptr - rptr;
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DP; i++) begin
                mem[i] <= '0;
            end
        end else if (commit_abort) begin
            // Flush only rewinds the pointers; stale storage is never visible while empty.
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) begin
                mem[wptr[AW-1:0]] <= dispat_info;
                wptr              <= wptr + PTR_ONE;
            end
            if (pop_ok) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_reorder_fifo.sv
// Directed bench for reorder_fifo: driver tasks feed an expected queue, a negedge monitor checks pops.
// Occupancy checks are compiled in only when REORDER_OCCUPANCY_EN is defined.
`ifndef RB
`define RB 6
`endif
`ifndef REORDER_INFO_DW
`define REORDER_INFO_DW (64 + 5 + `RB + 6)
`endif

module tb_reorder_fifo;

    localparam int W  = `REORDER_INFO_DW;
    localparam int DP = 4;
    localparam int AW = $clog2(DP);

    logic         clk;
    logic         rst_n;
    logic [W-1:0] dispat_info;
    logic         push;
    logic         full;
    logic [W-1:0] commit_fifo;
    logic         empty;
    logic         pop;
    logic         abort;
`ifdef REORDER_OCCUPANCY_EN
    logic [AW:0]  occupancy;
`endif

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    reorder_fifo #(.DP(DP)) dut (
        .CLK                (clk),
        .RSTn               (rst_n),
        .dispat_info        (dispat_info),
        .reOrder_fifo_push  (push),
        .reOrder_fifo_full  (full),
        .commit_fifo        (commit_fifo),
        .reOrder_fifo_empty (empty),
        .reOrder_fifo_pop   (pop),
        .commit_abort       (abort)
`ifdef REORDER_OCCUPANCY_EN
        ,
        .reOrder_occupancy  (occupancy)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic [63:0] pc, input logic [4+`RB:0] rd0);
        logic [5:0] flags;
        flags = pc[7:2];
        return {pc, rd0, flags};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_occ(input string name, input int exp);
`ifdef REORDER_OCCUPANCY_EN
        check(name, W'(occupancy), W'(exp));
`endif
    endtask

    // Driver: hold inputs for one cycle, record the expected outcome, return 1 time unit after the edge.
    task automatic drive(input logic p, input logic q, input logic a,
                         input logic [W-1:0] rec, input logic exp_acc);
        push        = p;
        pop         = q;
        abort       = a;
        dispat_info = rec;
        if (a) exp_q.delete();
        else if (exp_acc) exp_q.push_back(rec);
        @(posedge clk);
        #1;
        push  = 1'b0;
        pop   = 1'b0;
        abort = 1'b0;
    endtask

    // Scoreboard monitor: every accepted pop must present the oldest expected record.
    always @(negedge clk) begin
        if (rst_n && pop && !empty && !abort) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %h expected no record", commit_fifo);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (commit_fifo !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %h expected %h", commit_fifo, e);
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        abort       = 1'b0;
        dispat_info = '0;
        #12;
        check("reset_empty", W'(empty), W'(1));
        check("reset_full", W'(full), W'(0));
        check("reset_commit", commit_fifo, '0);
        check_occ("reset_occ", 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill to full, drop a fifth push, drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, mk(64'h8000_0000 + 64'(4 * i), 11'(i)), 1'b1);
            check("fill_full", W'(full), W'(i == 3));
            check("fill_empty", W'(empty), W'(0));
        end
        check_occ("fill_occ", 4);
        drive(1'b1, 1'b0, 1'b0, mk(64'h8000_0010, 11'd9), 1'b0);
        check("drop_full", W'(full), W'(1));
        check("drop_head_pc", W'(commit_fifo[W-1 -: 64]), W'(64'h8000_0000));
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
            check("drain_empty", W'(empty), W'(i == 3));
            check("drain_full", W'(full), W'(0));
        end

        // Push and pop on an empty FIFO: only the push lands
        drive(1'b1, 1'b1, 1'b0, mk(64'h100, 11'd1), 1'b1);
        check("pp_empty_empty", W'(empty), W'(0));
        check("pp_empty_pc", W'(commit_fifo[W-1 -: 64]), W'(64'h100));
        check_occ("pp_empty_occ", 1);
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, mk(64'h100 + 64'(4 * i), 11'(i + 1)), 1'b1);
        end
        check("pp_full_pre", W'(full), W'(1));

        // Push and pop on a full FIFO: only the pop lands
        drive(1'b1, 1'b1, 1'b0, mk(64'h110, 11'd5), 1'b0);
        check("pp_full_full", W'(full), W'(0));
        check("pp_full_head", W'(commit_fifo[W-1 -: 64]), W'(64'h104));
        check_occ("pp_full_occ", 3);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
        end
        check("pp_full_drained", W'(empty), W'(1));

        // Wrap-around: streaming push+pop with rd0 = 0..9
        drive(1'b1, 1'b0, 1'b0, mk(64'h4000, 11'd0), 1'b1);
        for (int i = 1; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b0, mk(64'h4000 + 64'(4 * i), 11'(i)), 1'b1);
            check("wrap_empty", W'(empty), W'(0));
            check("wrap_full", W'(full), W'(0));
            check("wrap_rd0", W'(commit_fifo[W-65 -: 5+`RB]), W'(i));
            check_occ("wrap_occ", 1);
        end
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
        check("wrap_end_empty", W'(empty), W'(1));

        // Abort with push and pop in the same cycle
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, mk(64'h300 + 64'(4 * i), 11'(i)), 1'b1);
        end
        drive(1'b1, 1'b1, 1'b1, mk(64'h3f0, 11'd7), 1'b0);
        check("abort_empty", W'(empty), W'(1));
        check("abort_full", W'(full), W'(0));
        check_occ("abort_occ", 0);
        drive(1'b1, 1'b0, 1'b0, mk(64'h200, 11'd2), 1'b1);
        check("post_abort_empty", W'(empty), W'(0));
        check("post_abort_pc", W'(commit_fifo[W-1 -: 64]), W'(64'h200));
        check_occ("post_abort_occ", 1);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0);

        // Asynchronous reset mid-stream with two records held
        drive(1'b1, 1'b0, 1'b0, mk(64'h500, 11'd3), 1'b1);
        drive(1'b1, 1'b0, 1'b0, mk(64'h504, 11'd4), 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("async_rst_empty", W'(empty), W'(1));
        check("async_rst_commit", commit_fifo, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("post_rst_empty", W'(empty), W'(1));
        check("post_rst_commit", commit_fifo, '0);
        check_occ("post_rst_occ", 0);

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: got %0d records expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
